glb_stream_tx: RTL and testbench



---
 rtl/glb_stream_pkg.sv | 15 +
 rtl/glb_tx_mem.sv | 24 ++
 rtl/glb_stream_tx.sv | 130 +++++++++++++
 tb/tb_glb_stream_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/glb_stream_pkg.sv
// Shared constants and state encoding for the GLB stream transmitter.
package glb_stream_pkg;

  localparam int DATA_W = 17;
  localparam logic [DATA_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SEND  = 3'd2,
    ST_TOKEN = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_t;

endpackage

// File: rtl/glb_tx_mem.sv
// Local word buffer: one write port, one combinational read port, entries hold {p, data}.
module glb_tx_mem
  import glb_stream_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W:0]   rdata
);

  logic [DATA_W:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/glb_stream_tx.sv
// Streams num_blocks blocks of blk_len buffered words, each followed by a DONE token.
module glb_stream_tx
  import glb_stream_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_p,
  input  logic [ADDR_W:0]   cfg_blk_len,
  input  logic [15:0]       cfg_num_blocks,
  output logic [DATA_W-1:0] data,
  output logic              data_p,
  output logic              valid,
  input  logic              ready,
  output logic              done,
  output tx_state_t         dbg_state
);

  // Handshake: a word transfers on a posedge where valid && ready; once valid is
  // raised, data/data_p/valid hold until that transfer (only flush or reset drop it).

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  tx_state_t         state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   len_q;
  logic [15:0]       blk_cnt;
  logic [15:0]       nblk_q;
  logic [DATA_W:0]   rd_word;
  logic              we;
  logic              hs;
  logic [15:0]       blk_inc;

  assign we        = ld_en && (state == ST_IDLE || state == ST_ARM || state == ST_DONE);
  assign hs        = valid && ready;
  assign blk_inc   = blk_cnt + 16'd1;
  assign dbg_state = state;

  glb_tx_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (ld_addr),
    .wdata ({ld_p, ld_data}),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // rd_addr always points at the next payload word to load into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      data     <= '0;
      data_p   <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
      rd_addr  <= '0;
      word_cnt <= '0;
      blk_cnt  <= '0;
      len_q    <= '0;
      nblk_q   <= '0;
    end else if (flush) begin
      state    <= ST_ARM;
      valid    <= 1'b0;
      done     <= 1'b0;
      rd_addr  <= '0;
      word_cnt <= '0;
      blk_cnt  <= '0;
    end else begin
      case (state)
        ST_ARM: begin
          len_q  <= cfg_blk_len;
          nblk_q <= cfg_num_blocks;
          if (cfg_num_blocks == 16'd0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (cfg_blk_len == '0) begin
            state  <= ST_TOKEN;
            data   <= DONE_TOKEN;
            data_p <= 1'b0;
            valid  <= 1'b1;
          end else begin
            state            <= ST_SEND;
            {data_p, data}   <= rd_word;
            valid            <= 1'b1;
            rd_addr          <= rd_addr + ADDR_ONE;
            word_cnt         <= CNT_ONE;
          end
        end
        ST_SEND: begin
          if (hs) begin
            if (word_cnt == len_q) begin
              state  <= ST_TOKEN;
              data   <= DONE_TOKEN;
              data_p <= 1'b0;
            end else begin
              {data_p, data} <= rd_word;
              rd_addr        <= rd_addr + ADDR_ONE;
              word_cnt       <= word_cnt + CNT_ONE;
            end
          end
        end
        ST_TOKEN: begin
          if (hs) begin
            blk_cnt <= blk_inc;
            if (blk_inc == nblk_q) begin
              state <= ST_DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end else if (len_q != '0) begin
              state          <= ST_SEND;
              {data_p, data} <= rd_word;
              rd_addr        <= rd_addr + ADDR_ONE;
              word_cnt       <= CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_stream_tx.sv
// Self-checking bench for glb_stream_tx: buffer model, expected-word queue, stall/abort/reset cases.
module tb_glb_stream_tx;
  import glb_stream_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [16:0]       ld_data = '0;
  logic              ld_p = 1'b0;
  logic [ADDR_W:0]   cfg_blk_len = '0;
  logic [15:0]       cfg_num_blocks = '0;
  logic [16:0]       data;
  logic              data_p;
  logic              valid;
  logic              ready = 1'b0;
  logic              done;
  tx_state_t         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] tb_mem [DEPTH];
  logic        mon_en = 1'b0;
  logic        hold_prev = 1'b0;
  logic [17:0] hold_word = '0;

  glb_stream_tx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_p(ld_p), .cfg_blk_len(cfg_blk_len),
    .cfg_num_blocks(cfg_num_blocks), .data(data), .data_p(data_p), .valid(valid),
    .ready(ready), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_word(input int addr, input logic [16:0] d, input logic p);
    ld_en   = 1'b1;
    ld_addr = addr[ADDR_W-1:0];
    ld_data = d;
    ld_p    = p;
    @(posedge clk); #1;
    ld_en   = 1'b0;
    tb_mem[addr] = {p, d};
  endtask

  task automatic push_stream(input int len, input int nblk);
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < len; i++) exp_q.push_back(tb_mem[(b * len + i) % DEPTH]);
      exp_q.push_back({1'b0, 17'h10100});
    end
  endtask

  task automatic start_stream(input int len, input int nblk);
    cfg_blk_len    = len[ADDR_W:0];
    cfg_num_blocks = nblk[15:0];
    push_stream(len, nblk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("arm_state", dbg_state, ST_ARM);
    flush = 1'b0;
    @(posedge clk); #1;
    chk("first_valid", valid, (nblk != 0) ? 1 : 0);
  endtask

  task automatic finish_stream(input int words, input bit full_rate, input bit rnd);
    int cyc = 0;
    while (!done && cyc < 1000) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    ready = 1'b1;
    chk("done_seen", done, 1);
    chk("queue_drained", exp_q.size(), 0);
    if (full_rate) chk("cycles", cyc, words);
    chk("done_no_valid", valid, 0);
    @(posedge clk); #1;
    chk("done_sticky", done, 1);
  endtask

  // Every accepted word is checked against the queue; stalled words must hold.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (hold_prev) begin
        chk("hold_valid", valid, 1);
        chk("hold_word", {data_p, data}, hold_word);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) chk("spurious_word", exp_q.size(), 1);
        else chk("stream_word", {data_p, data}, exp_q.pop_front());
      end
    end
    hold_prev = mon_en && rst_n && valid && !ready && !flush;
    hold_word = {data_p, data};
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", data, 0);
    chk("rst_data_p", data_p, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Basic 3-word block at full rate.
    for (int a = 0; a < DEPTH; a++) tb_mem[a] = '0;
    load_word(0, 17'h1, 1'b0);
    load_word(1, 17'h2, 1'b1);
    load_word(2, 17'h3, 1'b0);
    ready = 1'b1;
    start_stream(3, 1);
    finish_stream(4, 1'b1, 1'b0);

    // Stall three cycles while the second word is presented.
    start_stream(3, 1);
    @(posedge clk); #1;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_data", data, 17'h2);
      chk("stall_valid", valid, 1);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    finish_stream(0, 1'b0, 1'b0);

    // Two blocks of two, including a payload word equal to the token.
    load_word(0, 17'hA, 1'b0);
    load_word(1, 17'hB, 1'b1);
    load_word(2, 17'h10100, 1'b1);
    load_word(3, 17'hD, 1'b0);
    start_stream(2, 2);
    finish_stream(6, 1'b1, 1'b0);

    // Zero-length blocks: tokens only.
    start_stream(0, 3);
    finish_stream(3, 1'b1, 1'b0);

    // Zero blocks: straight to done.
    start_stream(2, 0);
    finish_stream(0, 1'b1, 1'b0);

    // Address wrap with random back-pressure.
    for (int a = 0; a < DEPTH; a++) load_word(a, 17'($urandom_range(0, 17'h1ffff)), 1'($urandom_range(0, 1)));
    start_stream(3, 6);
    finish_stream(0, 1'b0, 1'b1);
    start_stream(5, 4);
    finish_stream(0, 1'b0, 1'b1);

    // Abort after two of five words, then restart from address 0.
    ready = 1'b1;
    start_stream(5, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", valid, 0);
    chk("abort_state", dbg_state, ST_ARM);
    exp_q.delete();
    ready = 1'b1;
    start_stream(5, 1);
    finish_stream(6, 1'b1, 1'b0);

    // Asynchronous reset mid-SEND; a load during SEND must be ignored.
    ready = 1'b0;
    start_stream(4, 1);
    ld_en = 1'b1; ld_addr = '0; ld_data = 17'h1ffff; ld_p = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_data", data, 0);
    chk("async_data_p", data_p, 0);
    chk("async_valid", valid, 0);
    chk("async_done", done, 0);
    chk("async_state", dbg_state, ST_IDLE);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    start_stream(4, 1);
    finish_stream(5, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
